// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: word-addressed RAM behind a fixed-latency read
// pipeline, feeding a credit-limited response FIFO; backdoor port for preload.
module instr_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_addr,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_instr,
  output logic [31:0]                 rsp_addr,
  output logic                        rsp_err,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DEPTH_LOG2-1:0]       wr_addr,
  input  logic [31:0]                 wr_data,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] instr;
  } rsp_t;

  logic [31:0]           mem [WORDS];
  logic [LATENCY-1:0]    pipe_valid;
  rsp_t                  pipe_data [LATENCY];
  rsp_t                  fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  ready_en;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  req_err;
  logic [DEPTH_LOG2-1:0] req_idx;
  rsp_t                  head;

  // Misaligned or beyond the last word: answered with a zero (no-op) word.
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);
  assign req_idx = req_addr[DEPTH_LOG2+1:2];

  // Credit check counts in-flight plus queued entries, so the FIFO can never overflow.
  assign req_ready = ready_en && !flush && (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = pipe_valid[LATENCY-1];
  assign rsp_valid = (wr_ptr != rd_ptr);
  assign pop       = rsp_valid && rsp_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en   <= 1'b0;
      pipe_valid <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        pipe_valid <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        occupancy  <= '0;
      end else begin
        pipe_valid[0] <= accept;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
        end
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        occupancy <= occupancy + OCC_W'(accept) - OCC_W'(pop);
      end
    end
  end

  // NOTE: RAM, pipeline payload and FIFO storage carry no reset; only the valid
  // bits and pointers do, which is enough to hide stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_data[0].err   <= req_err;
      pipe_data[0].addr  <= req_addr;
      pipe_data[0].instr <= req_err ? 32'h0000_0000 : mem[req_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
    if (push) fifo_data[wr_ptr[PTR_W-1:0]] <= pipe_data[LATENCY-1];
  end

  // A read in the same cycle as a write to that word sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_en && reset_n) mem[wr_addr] <= wr_data;
  end

  // NOTE: default assigned first so no path through the block infers a latch.
  always_comb begin
    head = '0;
    if (rsp_valid) head = fifo_data[rd_ptr[PTR_W-1:0]];
  end

  assign rsp_instr = head.instr;
  assign rsp_addr  = head.addr;
  assign rsp_err   = head.err;

endmodule
